// File: rtl/conv_dma_pkg.sv
// Shared definitions for the CONV DMA read concentrator: payload field layout,
// response-routing tag and fixed channel indices.
package conv_dma_pkg;

  localparam int unsigned CH_DAT = 0;
  localparam int unsigned CH_WT  = 1;

  // Tag fields are sized for the largest supported configuration (8 channels, LEN_W <= 16).
  localparam int unsigned TAG_CH_W  = 3;
  localparam int unsigned TAG_LEN_W = 16;

  typedef struct packed {
    logic [TAG_CH_W-1:0]  ch_id;
    logic [TAG_LEN_W-1:0] len;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

  // Request payload is {len, addr, size} with size in the LSBs.
  function automatic int unsigned req_size_lsb();
    return 0;
  endfunction

  function automatic int unsigned req_addr_lsb(input int unsigned size_w);
    return size_w;
  endfunction

  function automatic int unsigned req_len_lsb(input int unsigned addr_w,
                                              input int unsigned size_w);
    return addr_w + size_w;
  endfunction

  function automatic int unsigned req_w(input int unsigned len_w, input int unsigned addr_w,
                                        input int unsigned size_w);
    return len_w + addr_w + size_w;
  endfunction

endpackage

// File: rtl/conv_dma_tag_fifo.sv
// Synchronous tag FIFO with full/empty/count flags; push and pop may coincide even when full.
module conv_dma_tag_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH+1);

  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CNTW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  function automatic logic [AW-1:0] nxt_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= nxt_ptr(r_wptr);
      if (w_pop)  r_rptr <= nxt_ptr(r_rptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/conv_dma_rd_arb.sv
// Round-robin merge of NUM_CH DMA read requesters onto one MCIF read port with in-order
// response routing. Optional per-channel beat counters under CONV_DMA_RD_ARB_PERF_EN.
module conv_dma_rd_arb
  import conv_dma_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned SIZE_W    = 32,
  parameter int unsigned DW        = 256,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CH-1:0]                             ch_req_vld,
  output logic [NUM_CH-1:0]                             ch_req_rdy,
  input  logic [NUM_CH*(LEN_W+ADDR_W+SIZE_W)-1:0]       ch_req_pd,
  output logic [NUM_CH-1:0]                             ch_resp_vld,
  input  logic [NUM_CH-1:0]                             ch_resp_rdy,
  output logic [DW-1:0]                                 ch_resp_pd,
  output logic                                          ch_resp_last,
  output logic                                          mcif_req_vld,
  input  logic                                          mcif_req_rdy,
  output logic [LEN_W+ADDR_W+SIZE_W-1:0]                mcif_req_pd,
  input  logic                                          mcif_resp_vld,
  output logic                                          mcif_resp_rdy,
  input  logic [DW-1:0]                                 mcif_resp_pd,
  output logic [NUM_CH*($clog2(MAX_OUTST)+1)-1:0]       outst_cnt,
  output logic                                          err_orphan
`ifdef CONV_DMA_RD_ARB_PERF_EN
  ,
  input  logic                                          perf_clr,
  output logic [NUM_CH*32-1:0]                          perf_beat_cnt
`endif
);

  localparam int unsigned PD_W    = req_w(LEN_W, ADDR_W, SIZE_W);
  localparam int unsigned LEN_LSB = req_len_lsb(ADDR_W, SIZE_W);
  localparam int unsigned CW      = $clog2(MAX_OUTST) + 1;
  localparam int unsigned IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DEPTH   = NUM_CH * MAX_OUTST;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

  logic [IW-1:0]          r_rr_ptr;
  logic                   r_req_vld;
  logic [PD_W-1:0]        r_req_pd;
  logic [NUM_CH*CW-1:0]   r_outst;
  logic [LEN_W-1:0]       r_beat;
  logic                   r_err;

  logic [NUM_CH-1:0]      w_elig;
  logic                   w_can_load;
  logic                   w_gnt_vld;
  logic [IW-1:0]          w_gnt_idx;
  logic [PD_W-1:0]        w_sel_pd;
  tag_t                   w_push_tag;
  tag_t                   w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH+1)-1:0] w_count;
  logic [IW-1:0]          w_h;
  logic                   w_ne;
  logic                   w_last;
  logic                   w_beat_ok;
  logic                   w_pop;

  assign w_can_load = !r_req_vld || mcif_req_rdy;
  assign w_ne       = !w_empty;
  assign w_h        = w_head.ch_id[IW-1:0];
  assign w_last     = (r_beat == w_head.len[LEN_W-1:0]);
  assign w_beat_ok  = mcif_resp_vld && w_ne && ch_resp_rdy[w_h];
  assign w_pop      = w_beat_ok && w_last;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_elig[i] = ch_req_vld[i] && (r_outst[i*CW +: CW] < MAX_CNT) && (!w_full || w_pop) &&
                  w_can_load && !rst;
    end
  end

  // Scan from the pointer; the first eligible channel wins.
  always_comb begin : p_arb
    int v_idx;
    v_idx     = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= int'(NUM_CH)) v_idx = v_idx - int'(NUM_CH);
      if (!w_gnt_vld && w_elig[v_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IW'(v_idx);
      end
    end
  end

  always_comb begin
    ch_req_rdy = '0;
    if (w_gnt_vld) ch_req_rdy[w_gnt_idx] = 1'b1;
  end

  assign w_sel_pd         = ch_req_pd[32'(w_gnt_idx)*PD_W +: PD_W];
  assign w_push_tag.ch_id = TAG_CH_W'(w_gnt_idx);
  assign w_push_tag.len   = TAG_LEN_W'(w_sel_pd[LEN_LSB +: LEN_W]);

  conv_dma_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_gnt_vld),
    .i_data  (w_push_tag),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_req_vld <= 1'b0;
      r_req_pd  <= '0;
    end else begin
      if (w_can_load) begin
        r_req_vld <= w_gnt_vld;
        if (w_gnt_vld) r_req_pd <= w_sel_pd;
      end
      if (w_gnt_vld) begin
        r_rr_ptr <= (w_gnt_idx == IW'(NUM_CH-1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  // A grant and a final-beat pop on the same channel cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outst <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((w_gnt_vld && w_gnt_idx == IW'(i)) && !(w_pop && w_h == IW'(i))) begin
          r_outst[i*CW +: CW] <= r_outst[i*CW +: CW] + 1'b1;
        end else if (!(w_gnt_vld && w_gnt_idx == IW'(i)) && (w_pop && w_h == IW'(i))) begin
          r_outst[i*CW +: CW] <= r_outst[i*CW +: CW] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_beat_ok) r_beat <= w_last ? '0 : r_beat + 1'b1;
      if (mcif_resp_vld && w_empty) r_err <= 1'b1;
    end
  end

  always_comb begin
    ch_resp_vld = '0;
    if (mcif_resp_vld && w_ne) ch_resp_vld[w_h] = 1'b1;
  end

  // With no tag outstanding the beat is swallowed so MCIF never stalls on it.
  assign mcif_resp_rdy = w_ne ? ch_resp_rdy[w_h] : (mcif_resp_vld && !rst);
  assign ch_resp_pd    = (mcif_resp_vld && w_ne) ? mcif_resp_pd : '0;
  assign ch_resp_last  = mcif_resp_vld && w_ne && w_last;
  assign mcif_req_vld  = r_req_vld;
  assign mcif_req_pd   = r_req_pd;
  assign outst_cnt     = r_outst;
  assign err_orphan    = r_err;

`ifdef CONV_DMA_RD_ARB_PERF_EN
  logic [NUM_CH*32-1:0] r_perf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (perf_clr) begin
          r_perf[i*32 +: 32] <= '0;
        end else if (w_beat_ok && w_h == IW'(i) && r_perf[i*32 +: 32] != 32'hFFFF_FFFF) begin
          r_perf[i*32 +: 32] <= r_perf[i*32 +: 32] + 32'd1;
        end
      end
    end
  end

  assign perf_beat_cnt = r_perf;
`endif

endmodule

// File: tb/tb_conv_dma_rd_arb.sv
// Directed bench for conv_dma_rd_arb: reset, fairness, credit stall, backpressure, orphan, reset
// mid-burst, and beat counters when CONV_DMA_RD_ARB_PERF_EN is defined.
module tb_conv_dma_rd_arb;

  localparam int NUM_CH = 2;
  localparam int LEN_W = 8;
  localparam int ADDR_W = 32;
  localparam int SIZE_W = 32;
  localparam int DW = 256;
  localparam int MAX_OUTST = 8;
  localparam int PD_W = LEN_W + ADDR_W + SIZE_W;
  localparam int CW = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_req_vld, ch_req_rdy, ch_resp_vld, ch_resp_rdy;
  logic [NUM_CH*PD_W-1:0]   ch_req_pd;
  logic [DW-1:0]            ch_resp_pd, mcif_resp_pd;
  logic                     ch_resp_last, mcif_req_vld, mcif_req_rdy;
  logic                     mcif_resp_vld, mcif_resp_rdy, err_orphan;
  logic [PD_W-1:0]          mcif_req_pd;
  logic [NUM_CH*CW-1:0]     outst_cnt;
  logic [DW-1:0]            exp_d;
`ifdef CONV_DMA_RD_ARB_PERF_EN
  logic                     perf_clr;
  logic [NUM_CH*32-1:0]     perf_beat_cnt;
`endif

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_dma_rd_arb #(
    .NUM_CH    (NUM_CH),
    .LEN_W     (LEN_W),
    .ADDR_W    (ADDR_W),
    .SIZE_W    (SIZE_W),
    .DW        (DW),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_req_vld    (ch_req_vld),
    .ch_req_rdy    (ch_req_rdy),
    .ch_req_pd     (ch_req_pd),
    .ch_resp_vld   (ch_resp_vld),
    .ch_resp_rdy   (ch_resp_rdy),
    .ch_resp_pd    (ch_resp_pd),
    .ch_resp_last  (ch_resp_last),
    .mcif_req_vld  (mcif_req_vld),
    .mcif_req_rdy  (mcif_req_rdy),
    .mcif_req_pd   (mcif_req_pd),
    .mcif_resp_vld (mcif_resp_vld),
    .mcif_resp_rdy (mcif_resp_rdy),
    .mcif_resp_pd  (mcif_resp_pd),
    .outst_cnt     (outst_cnt),
    .err_orphan    (err_orphan)
`ifdef CONV_DMA_RD_ARB_PERF_EN
    ,
    .perf_clr      (perf_clr),
    .perf_beat_cnt (perf_beat_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [PD_W-1:0] mk_pd(input logic [7:0] len, input logic [31:0] addr,
                                            input logic [31:0] size);
    return {len, addr, size};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pd(input int ch, input logic [PD_W-1:0] pd);
    ch_req_pd[ch*PD_W +: PD_W] = pd;
  endtask

  initial begin
    rst = 1'b1;
    ch_req_vld = '0;
    ch_req_pd = '0;
    ch_resp_rdy = '0;
    mcif_req_rdy = 1'b0;
    mcif_resp_vld = 1'b0;
    mcif_resp_pd = '0;
`ifdef CONV_DMA_RD_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_vld", mcif_req_vld, 0);
    chk("rst_req_pd", mcif_req_pd, 0);
    chk("rst_outst", outst_cnt, 0);
    chk("rst_err", err_orphan, 0);
    chk("rst_mresp_rdy", mcif_resp_rdy, 0);
    chk("rst_resp_vld", ch_resp_vld, 0);
    rst = 1'b0;
    ch_resp_rdy = '1;
    mcif_req_rdy = 1'b1;
    tick();

    // Fairness: both channels always valid, grants alternate starting at ch0
    set_pd(0, mk_pd(8'd0, 32'h2000, 32'd0));
    set_pd(1, mk_pd(8'd0, 32'h3000, 32'd1));
    ch_req_vld = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fair_rdy", ch_req_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("fair_pd", mcif_req_pd,
          (i % 2 == 0) ? mk_pd(8'd0, 32'h2000, 32'd0) : mk_pd(8'd0, 32'h3000, 32'd1));
    end
    ch_req_vld = '0;
    chk("fair_outst", outst_cnt, 8'h44);
    tick();
    chk("fair_drain", mcif_req_vld, 0);
    mcif_resp_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fair_route", ch_resp_vld, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("fair_last", ch_resp_last, 1);
      tick();
    end
    mcif_resp_vld = 1'b0;
    chk("fair_outst0", outst_cnt, 0);

    // Single request, len=3
    set_pd(0, mk_pd(8'd3, 32'h1000, 32'hAB));
    ch_req_vld = 2'b01;
    #1;
    chk("single_rdy", ch_req_rdy, 2'b01);
    chk("single_pre", mcif_req_vld, 0);
    tick();
    ch_req_vld = '0;
    chk("single_vld", mcif_req_vld, 1);
    chk("single_pd", mcif_req_pd, mk_pd(8'd3, 32'h1000, 32'hAB));
    chk("single_outst", outst_cnt, 8'h01);
    tick();
    chk("single_vld_clr", mcif_req_vld, 0);
    mcif_resp_vld = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp_d = {8{32'hD000_0000 | 32'(b)}};
      mcif_resp_pd = exp_d;
      #1;
      chk("single_route", ch_resp_vld, 2'b01);
      chk("single_data", ch_resp_pd, exp_d);
      chk("single_last", ch_resp_last, (b == 3) ? 1 : 0);
      tick();
    end
    mcif_resp_vld = 1'b0;
    chk("single_outst0", outst_cnt, 0);

    // Credit stall: ch1 fills its 8 credits
    set_pd(1, mk_pd(8'd1, 32'h4000, 32'd2));
    set_pd(0, mk_pd(8'd0, 32'h5000, 32'd3));
    ch_req_vld = 2'b10;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("credit_rdy", ch_req_rdy, 2'b10);
      tick();
    end
    #1;
    chk("credit_stall", ch_req_rdy, 0);
    chk("credit_cnt8", outst_cnt, 8'h80);
    ch_req_vld = 2'b11;
    #1;
    chk("credit_ch0", ch_req_rdy, 2'b01);
    tick();
    ch_req_vld = 2'b10;
    chk("credit_cnt81", outst_cnt, 8'h81);
    mcif_resp_vld = 1'b1;
    #1;
    chk("credit_b0_vld", ch_resp_vld, 2'b10);
    chk("credit_b0_rdy", ch_req_rdy, 0);
    tick();
    #1;
    chk("credit_b1_last", ch_resp_last, 1);
    chk("credit_b1_rdy", ch_req_rdy, 0);
    tick();
    mcif_resp_vld = 1'b0;
    #1;
    chk("credit_resume", ch_req_rdy, 2'b10);
    chk("credit_cnt71", outst_cnt, 8'h71);
    tick();
    ch_req_vld = '0;
    mcif_resp_vld = 1'b1;
    repeat (17) tick();
    mcif_resp_vld = 1'b0;
    chk("credit_outst0", outst_cnt, 0);
    chk("credit_no_orphan", err_orphan, 0);

    // Response backpressure on ch1
    set_pd(1, mk_pd(8'd1, 32'h6000, 32'd4));
    ch_req_vld = 2'b10;
    tick();
    ch_req_vld = '0;
    tick();
    ch_resp_rdy = 2'b01;
    mcif_resp_vld = 1'b1;
    #1;
    chk("bp_mrdy0", mcif_resp_rdy, 0);
    chk("bp_vld", ch_resp_vld, 2'b10);
    tick();
    chk("bp_hold_vld", ch_resp_vld, 2'b10);
    chk("bp_hold_last", ch_resp_last, 0);
    chk("bp_outst", outst_cnt, 8'h10);
    ch_resp_rdy = 2'b11;
    #1;
    chk("bp_mrdy1", mcif_resp_rdy, 1);
    tick();
    #1;
    chk("bp_last", ch_resp_last, 1);
    tick();
    mcif_resp_vld = 1'b0;
    chk("bp_outst0", outst_cnt, 0);

    // Request backpressure: payload held for 5 stalled cycles
    mcif_req_rdy = 1'b0;
    set_pd(0, mk_pd(8'd0, 32'h7000, 32'd5));
    ch_req_vld = 2'b01;
    tick();
    set_pd(0, mk_pd(8'd0, 32'h7100, 32'd6));
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bpq_rdy", ch_req_rdy, 0);
      chk("bpq_vld", mcif_req_vld, 1);
      chk("bpq_pd", mcif_req_pd, mk_pd(8'd0, 32'h7000, 32'd5));
      tick();
    end
    mcif_req_rdy = 1'b1;
    #1;
    chk("bpq_reload", ch_req_rdy, 2'b01);
    tick();
    ch_req_vld = '0;
    chk("bpq_pd2", mcif_req_pd, mk_pd(8'd0, 32'h7100, 32'd6));
    tick();
    chk("bpq_drain", mcif_req_vld, 0);
    mcif_resp_vld = 1'b1;
    repeat (2) tick();
    mcif_resp_vld = 1'b0;
    chk("bpq_outst0", outst_cnt, 0);

    // Orphan beat
    mcif_resp_vld = 1'b1;
    #1;
    chk("orph_rdy", mcif_resp_rdy, 1);
    chk("orph_vld", ch_resp_vld, 0);
    tick();
    mcif_resp_vld = 1'b0;
    #1;
    chk("orph_err", err_orphan, 1);
    tick();
    chk("orph_sticky", err_orphan, 1);

    // Reset mid-burst with a request still parked in the output register
    set_pd(0, mk_pd(8'd3, 32'h8000, 32'd7));
    ch_req_vld = 2'b01;
    mcif_req_rdy = 1'b0;
    tick();
    ch_req_vld = '0;
    mcif_resp_vld = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_req_vld", mcif_req_vld, 0);
    chk("mrst_req_pd", mcif_req_pd, 0);
    chk("mrst_outst", outst_cnt, 0);
    chk("mrst_err", err_orphan, 0);
    chk("mrst_resp_vld", ch_resp_vld, 0);
    chk("mrst_mrdy", mcif_resp_rdy, 0);
    chk("mrst_last", ch_resp_last, 0);
    tick();
    rst = 1'b0;
    mcif_resp_vld = 1'b0;
    mcif_req_rdy = 1'b1;
    tick();
    set_pd(0, mk_pd(8'd0, 32'h9000, 32'd8));
    ch_req_vld = 2'b01;
    #1;
    chk("post_rdy", ch_req_rdy, 2'b01);
    tick();
    ch_req_vld = '0;
    chk("post_vld", mcif_req_vld, 1);
    chk("post_pd", mcif_req_pd, mk_pd(8'd0, 32'h9000, 32'd8));
    mcif_resp_vld = 1'b1;
    #1;
    chk("post_route", ch_resp_vld, 2'b01);
    chk("post_last", ch_resp_last, 1);
    tick();
    mcif_resp_vld = 1'b0;
    chk("post_outst0", outst_cnt, 0);
    chk("post_err", err_orphan, 0);

`ifdef CONV_DMA_RD_ARB_PERF_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    set_pd(0, mk_pd(8'd7, 32'hA000, 32'd9));
    ch_req_vld = 2'b01;
    repeat (3) tick();
    ch_req_vld = '0;
    tick();
    mcif_resp_vld = 1'b1;
    repeat (24) tick();
    mcif_resp_vld = 1'b0;
    chk("perf_cnt24", perf_beat_cnt[31:0], 24);
    chk("perf_outst0", outst_cnt, 0);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr", perf_beat_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_dma_rd_arb.md
Name: conv_dma_rd_arb

Overview:
- Parametrised read-port concentrator for the CONV DMA path. Merges NUM_CH DMA read requesters (ch0 = dat, ch1 = wt, further channels for new operand streams) onto one MCIF read port.
- Arbitrates requests round-robin, tracks outstanding bursts per channel, and routes in-order MCIF response beats back to the issuing channel.
- Sits between the dma_*_top engines and MCIF. Replaces the fixed pair of dedicated dat/wt MCIF ports.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8)
- LEN_W, 8, burst length field width; beats per burst = len+1
- ADDR_W, 32, address field width
- SIZE_W, 32, size/aux field width, carried transparently
- DW, 256, response data width
- MAX_OUTST, 8, max outstanding bursts per channel (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ch_req_vld  in  NUM_CH  per-channel request valid
- ch_req_rdy  out  NUM_CH  per-channel request ready
- ch_req_pd  in  NUM_CH*(LEN_W+ADDR_W+SIZE_W)  per-channel {len,addr,size}; channel i occupies slice i
- ch_resp_vld  out  NUM_CH  per-channel response valid
- ch_resp_rdy  in  NUM_CH  per-channel response ready
- ch_resp_pd  out  DW  response data, shared by all channels, qualified by ch_resp_vld
- ch_resp_last  out  1  final beat of the current burst
- mcif_req_vld  out  1  merged request valid
- mcif_req_rdy  in  1  MCIF request ready
- mcif_req_pd  out  LEN_W+ADDR_W+SIZE_W  merged request payload
- mcif_resp_vld  in  1  MCIF response valid (in issue order)
- mcif_resp_rdy  out  1  MCIF response ready
- mcif_resp_pd  in  DW  MCIF response data
- outst_cnt  out  NUM_CH*($clog2(MAX_OUTST)+1)  per-channel outstanding bursts
- err_orphan  out  1  sticky: response beat arrived with no outstanding tag

Behaviour:
- Reset (async, rst=1): all outputs 0; round-robin pointer 0; tag FIFO empty; counters 0; err_orphan cleared. rst asserted mid-burst drops all tracking, with no recovery of in-flight beats.
- Request stage: one output register (mcif_req_vld/pd).
  - Register loads when empty, or when mcif_req_rdy=1 in the same cycle.
  - Register holds payload stable while vld=1 and rdy=0.
- Eligibility of channel i: ch_req_vld[i]=1, outst_cnt[i]<MAX_OUTST, and the tag FIFO has a free entry.
- Arbitration: round-robin among eligible channels, starting at the pointer.
  - Grant asserts ch_req_rdy[i] for one cycle.
  - ch_req_rdy is combinational from ch_req_vld; no more than one bit is high per cycle.
  - Request latency: one cycle from grant to mcif_req_vld.
  - Pointer moves to granted index+1, wrapping at NUM_CH.
- On grant: push {ch_id,len} into the tag FIFO (depth NUM_CH*MAX_OUTST), and increment outst_cnt[ch].
- Response routing: the tag FIFO head selects channel h.
  - ch_resp_vld[h] = mcif_resp_vld & tag_nonempty.
  - mcif_resp_rdy = ch_resp_rdy[h] & tag_nonempty.
  - Data passes through combinationally, zero latency.
  - A beat counter counts accepted beats. ch_resp_last=1 when beat_cnt==len.
  - On the last beat accepted: pop the tag, clear beat_cnt, decrement outst_cnt[h].
- Simultaneous grant and final-beat decrement on the same channel: the counter is unchanged. Simultaneous push and pop on the tag FIFO are allowed when it is full.
- Orphan beat (mcif_resp_vld=1 with tag FIFO empty):
  - Beat is accepted and dropped: mcif_resp_rdy=1.
  - err_orphan sets and stays set until reset.
- len=0 is a single-beat burst, and ch_resp_last asserts on that beat.
- NUM_CH=1: arbiter degenerates to pass-through, with the same one-cycle register.

Optional Feature:
- Macro CONV_DMA_RD_ARB_PERF_EN.
- When defined: adds output perf_beat_cnt (NUM_CH*32) and input perf_clr.
  - Per-channel 32-bit count of accepted response beats.
  - Counters saturate at 0xFFFFFFFF and are cleared synchronously by perf_clr.
  - perf_clr wins over an increment in the same cycle.
- When undefined: those ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package conv_dma_pkg:
  - Request payload field offsets and widths (LEN/ADDR/SIZE).
  - Tag struct {ch_id, len}.
  - Channel index constants CH_DAT=0, CH_WT=1.
- Sub-module conv_dma_tag_fifo: synchronous FIFO with full, empty and count flags, and simultaneous push/pop.

Test Plan:
- Single request: ch0 len=3 addr=0x1000 → mcif_req_vld 1 cycle after grant with pd {3,0x1000,size}; 4 response beats go to ch0; ch_resp_last on beat 4; outst_cnt[0] returns 0.
- Fairness: ch0 and ch1 both continuously valid, mcif_req_rdy=1 → grants alternate 0,1,0,1 over 8 requests; tag FIFO order matches.
- Credit stall: MAX_OUTST=8, ch1 issues 8 bursts with no responses → ch_req_rdy[1] stays 0 on the 9th; ch0 is still granted; ch1 resumes one cycle after its first burst's last beat.
- Backpressure: ch_resp_rdy[1]=0 during a ch1 burst → mcif_resp_rdy=0 and the beat is held; mcif_req_rdy=0 for 5 cycles → mcif_req_pd stays stable.
- Orphan and reset: response beat with no outstanding request → err_orphan=1 and sticky; rst pulse mid-burst → all outputs 0, err_orphan=0, next request proceeds normally.
- Perf (CONV_DMA_RD_ARB_PERF_EN): 3 bursts of len=7 on ch0 → perf_beat_cnt[0]=24; perf_clr → 0.
